// File: rtl/freq_meter_scheduler.sv
// freq_meter_scheduler: four-channel gated edge counter with a round-robin channel
// scheduler and an 8-bit processor port register window.
`default_nettype none

module freq_meter_scheduler #(
  parameter logic [7:0]  BASE        = 8'h00,
  parameter int unsigned GATE_CYCLES = 80_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pps,
  input  logic [3:0] in,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  input  logic       read_strobe,
  output logic [7:0] in_port
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, COUNT = 2'd2, STORE = 2'd3} state_t;

  localparam logic [31:0] GATE_LAST = 32'(GATE_CYCLES - 1);

  state_t      state;
  logic [1:0]  pps_sync;
  logic        pps_prev;
  logic [3:0]  in_s1, in_s2;
  logic        en, src, src_run;
  logic [3:0]  mask;
  logic [31:0] gate_cnt;
  logic [31:0] count;
  logic [1:0]  ch;
  logic        edge_prev;
  logic [31:0] result [4];
  logic [3:0]  ready;

  logic [7:0]  off;
  logic        ctrl_wr, int_tick, gate, abort, cur_in;
  logic [3:0]  rd_clr;
  logic [1:0]  nxt;

  function automatic logic [1:0] lowest_ch(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 3; k >= 0; k--)
      if (m[k]) r = 2'(k);
    return r;
  endfunction

  // Next set bit strictly after cur, wrapping; falls back to cur when it is alone.
  function automatic logic [1:0] next_ch(input logic [1:0] cur, input logic [3:0] m);
    logic [1:0] r, c;
    r = cur;
    for (int k = 3; k >= 1; k--) begin
      c = cur + 2'(k);
      if (m[c]) r = c;
    end
    return r;
  endfunction

  assign off      = port_id - BASE;
  assign ctrl_wr  = write_strobe && (port_id == BASE);
  assign int_tick = (gate_cnt == GATE_LAST);
  assign gate     = src ? int_tick : (pps_sync[1] & ~pps_prev);
  assign abort    = !en || (src != src_run);
  assign cur_in   = in_s2[ch];
  assign nxt      = next_ch(ch, mask);

  always_comb begin
    rd_clr = 4'b0000;
    for (int n = 0; n < 4; n++)
      rd_clr[n] = read_strobe && (off == 8'(7 + 4 * n));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pps_sync <= 2'b00;
      pps_prev <= 1'b0;
      in_s1    <= 4'h0;
      in_s2    <= 4'h0;
    end else begin
      pps_sync <= {pps_sync[0], pps};
      pps_prev <= pps_sync[1];
      in_s1    <= in;
      in_s2    <= in_s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en       <= 1'b0;
      src      <= 1'b0;
      mask     <= 4'h0;
      gate_cnt <= 32'd0;
    end else begin
      if (ctrl_wr) begin
        en   <= out_port[0];
        src  <= out_port[1];
        mask <= out_port[7:4];
      end
      if (ctrl_wr || int_tick) gate_cnt <= 32'd0;
      else                     gate_cnt <= gate_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= 32'd0;
      ch        <= 2'd0;
      edge_prev <= 1'b0;
      src_run   <= 1'b0;
      ready     <= 4'h0;
      for (int n = 0; n < 4; n++) result[n] <= 32'd0;
    end else begin
      ready <= ready & ~rd_clr;
      case (state)
        IDLE: begin
          if (en && (mask != 4'h0)) begin
            state   <= ARM;
            ch      <= lowest_ch(mask);
            src_run <= src;
          end
        end
        ARM: begin
          if (abort) state <= IDLE;
          else if (gate) begin
            state     <= COUNT;
            count     <= 32'd0;
            edge_prev <= cur_in;
          end
        end
        COUNT: begin
          if (abort) state <= IDLE;
          else if (gate) state <= STORE;
          else begin
            edge_prev <= cur_in;
            if (cur_in && !edge_prev && (count != 32'hFFFF_FFFF))
              count <= count + 32'd1;
          end
        end
        STORE: begin
          result[ch] <= count;
          // A coincident read-clear loses to the store.
          ready      <= (ready & ~rd_clr) | (4'b0001 << ch);
          count      <= 32'd0;
          ch         <= nxt;
          edge_prev  <= in_s2[nxt];
          state      <= ((mask == 4'h0) || abort) ? IDLE : COUNT;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    logic [7:0] idx;
    in_port = 8'h00;
    idx     = off - 8'd4;
    if (off == 8'd0)
      in_port = {(state != IDLE), 1'b0, ch, ready};
    else if (off == 8'd1)
      in_port = {mask, 2'b00, src, en};
    else if ((off >= 8'd4) && (off <= 8'd19))
      in_port = 8'(result[idx[3:2]] >> (8 * (3 - int'(idx[1:0]))));
  end

endmodule

`default_nettype wire
